// File: rtl/ahb_write_master.sv
// AHB-Lite write initiator: queues local write requests in a FIFO and issues each
// as a single NONSEQ write, handling wait states, two-cycle ERROR and a wait timeout.
module ahb_write_master #(
  parameter int ADDR_WIDTH = 8,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_DEPTH = 4,
  parameter int TIMEOUT    = 16
) (
  input  logic                  hclk,
  input  logic                  hreset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [DATA_WIDTH-1:0] req_data,
  output logic                  hsel_x,
  output logic [ADDR_WIDTH-1:0] haddr,
  output logic [1:0]            htrans,
  output logic                  hwrite,
  output logic [DATA_WIDTH-1:0] hwdata,
  input  logic                  hready,
  input  logic                  hresp,
  output logic                  done,
  output logic                  err,
  output logic                  timeout,
  output logic                  busy,
  output logic [7:0]            err_count
);

  localparam int PTR_W  = $clog2(FIFO_DEPTH);
  localparam int CNT_W  = PTR_W + 1;
  localparam int WAIT_W = $clog2(TIMEOUT);

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;

  typedef enum logic [1:0] {S_IDLE, S_ADDR, S_DATA, S_ERR2} state_e;

  state_e                state_q, state_d;
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      count_q, count_d;
  logic [DATA_WIDTH-1:0] mem_q [FIFO_DEPTH];
  logic [ADDR_WIDTH-1:0] haddr_q, haddr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d, hwdata_q, hwdata_d;
  logic [ADDR_WIDTH-1:0] amem_q [FIFO_DEPTH];
  logic [1:0]            htrans_q, htrans_d;
  logic                  hwrite_q, hwrite_d, hsel_q, hsel_d;
  logic                  done_q, done_d, err_q, err_d, timeout_q, timeout_d;
  logic [7:0]            err_count_q, err_count_d;
  logic [WAIT_W-1:0]     wait_q, wait_d;
  logic                  push, pop, wait_limit;

  assign req_ready  = (count_q != CNT_W'(FIFO_DEPTH));
  assign push       = req_valid && req_ready;
  assign wait_limit = (wait_q == WAIT_W'(TIMEOUT - 1));

  // NOTE: storage is written without reset; the pointers and count alone define which entries are valid.
  always_ff @(posedge hclk) begin
    if (push) begin
      mem_q[wr_ptr_q]  <= req_data;
      amem_q[wr_ptr_q] <= req_addr;
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop)      count_d = count_q + CNT_W'(1);
    else if (pop && !push) count_d = count_q - CNT_W'(1);
  end

  // NOTE: every signal written here gets a default first, so no path leaves one unassigned and no latch is inferred.
  always_comb begin
    state_d   = state_q;
    haddr_d   = haddr_q;
    wdata_d   = wdata_q;
    hwdata_d  = hwdata_q;
    htrans_d  = htrans_q;
    hwrite_d  = hwrite_q;
    hsel_d    = hsel_q;
    wait_d    = wait_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    timeout_d = 1'b0;
    pop       = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        htrans_d = HTRANS_IDLE;
        hwrite_d = 1'b0;
        hsel_d   = 1'b0;
        if (count_q != '0) begin
          pop      = 1'b1;
          haddr_d  = amem_q[rd_ptr_q];
          wdata_d  = mem_q[rd_ptr_q];
          htrans_d = HTRANS_NONSEQ;
          hwrite_d = 1'b1;
          hsel_d   = 1'b1;
          state_d  = S_ADDR;
        end
      end
      S_ADDR: begin
        if (hready) begin
          hwdata_d = wdata_q;
          htrans_d = HTRANS_IDLE;
          hwrite_d = 1'b0;
          wait_d   = '0;
          state_d  = S_DATA;
        end
      end
      S_DATA: begin
        if (hready) begin
          // hready high with ERROR is a protocol violation and is still reported as err.
          if (hresp) err_d = 1'b1;
          else       done_d = 1'b1;
          hsel_d  = 1'b0;
          state_d = S_IDLE;
        end else if (wait_limit) begin
          timeout_d = 1'b1;
          hsel_d    = 1'b0;
          state_d   = S_IDLE;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
          if (hresp) state_d = S_ERR2;
        end
      end
      S_ERR2: begin
        if (hready) begin
          err_d   = 1'b1;
          hsel_d  = 1'b0;
          state_d = S_IDLE;
        end else if (wait_limit) begin
          timeout_d = 1'b1;
          hsel_d    = 1'b0;
          state_d   = S_IDLE;
        end else begin
          wait_d = wait_q + WAIT_W'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
    err_count_d = err_count_q;
    if ((err_d || timeout_d) && (err_count_q != 8'hFF)) err_count_d = err_count_q + 8'd1;
  end

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge hclk or posedge hreset) begin
    if (hreset) begin
      state_q     <= S_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      count_q     <= '0;
      haddr_q     <= '0;
      wdata_q     <= '0;
      hwdata_q    <= '0;
      htrans_q    <= HTRANS_IDLE;
      hwrite_q    <= 1'b0;
      hsel_q      <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      timeout_q   <= 1'b0;
      err_count_q <= '0;
      wait_q      <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      haddr_q     <= haddr_d;
      wdata_q     <= wdata_d;
      hwdata_q    <= hwdata_d;
      htrans_q    <= htrans_d;
      hwrite_q    <= hwrite_d;
      hsel_q      <= hsel_d;
      done_q      <= done_d;
      err_q       <= err_d;
      timeout_q   <= timeout_d;
      err_count_q <= err_count_d;
      wait_q      <= wait_d;
    end
  end

  assign hsel_x    = hsel_q;
  assign haddr     = haddr_q;
  assign htrans    = htrans_q;
  assign hwrite    = hwrite_q;
  assign hwdata    = hwdata_q;
  assign done      = done_q;
  assign err       = err_q;
  assign timeout   = timeout_q;
  assign err_count = err_count_q;
  assign busy      = (state_q != S_IDLE) || (count_q != '0);

endmodule

// File: tb/tb_ahb_write_master.sv
// Self-checking bench for ahb_write_master: a scoreboard of expected completions is
// filled as requests are pushed and drained by a monitor when status pulses appear.
module tb_ahb_write_master;

  localparam logic [1:0] K_DONE = 2'd0;
  localparam logic [1:0] K_ERR  = 2'd1;
  localparam logic [1:0] K_TMO  = 2'd2;

  typedef struct {
    logic [7:0] addr;
    logic [7:0] data;
    logic [1:0] kind;
  } exp_t;

  logic       hclk, hreset, req_valid, req_ready;
  logic [7:0] req_addr, req_data, haddr, hwdata, err_count;
  logic [1:0] htrans;
  logic       hsel_x, hwrite, hready, hresp, done, err, timeout, busy;

  int   n_tests = 0;
  int   n_fail  = 0;
  int   cyc     = 0;
  int   exp_err = 0;
  exp_t sb[$];
  int   stamps[$];

  ahb_write_master dut (
    .hclk(hclk), .hreset(hreset), .req_valid(req_valid), .req_ready(req_ready),
    .req_addr(req_addr), .req_data(req_data), .hsel_x(hsel_x), .haddr(haddr),
    .htrans(htrans), .hwrite(hwrite), .hwdata(hwdata), .hready(hready),
    .hresp(hresp), .done(done), .err(err), .timeout(timeout), .busy(busy),
    .err_count(err_count)
  );

  initial begin
    hclk = 1'b0;
    forever #5 hclk = ~hclk;
  end

  always @(posedge hclk) cyc++;

  // Scoreboard monitor: every status pulse must match the oldest outstanding request.
  always @(posedge hclk) begin
    #1;
    if (done || err || timeout) begin
      exp_t e;
      logic [1:0] got;
      got = done ? K_DONE : (err ? K_ERR : K_TMO);
      stamps.push_back(cyc);
      n_tests++;
      if ((32'(done) + 32'(err) + 32'(timeout)) != 1) begin
        n_fail++;
        $display("FAIL pulse_exclusive: got done/err/timeout=%b%b%b expected one-hot", done, err, timeout);
      end else if (sb.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_pulse: got kind %0d addr %h expected no pulse", got, haddr);
      end else begin
        e = sb.pop_front();
        if (got !== e.kind || haddr !== e.addr || (e.kind == K_DONE && hwdata !== e.data)) begin
          n_fail++;
          $display("FAIL sb_completion: got kind %0d addr %h data %h expected kind %0d addr %h data %h",
                   got, haddr, hwdata, e.kind, e.addr, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic push(input logic [7:0] a, input logic [7:0] d, input bit accept, input logic [1:0] kind);
    exp_t e;
    if (accept) begin
      e.addr = a; e.data = d; e.kind = kind;
      sb.push_back(e);
    end
    req_valid = 1'b1;
    req_addr  = a;
    req_data  = d;
    @(negedge hclk);
    req_valid = 1'b0;
  endtask

  // Waits for the address phase, then steps one cycle into the data phase (hready must be high).
  task automatic wait_addr();
    for (int i = 0; i < 30; i++) begin
      if (htrans == 2'b10) break;
      @(negedge hclk);
    end
    n_tests++;
    if (htrans !== 2'b10) begin
      n_fail++;
      $display("FAIL addr_phase: got htrans %b expected 10 within 30 cycles", htrans);
    end
    @(negedge hclk);
  endtask

  task automatic wait_drain();
    for (int i = 0; i < 300; i++) begin
      if (sb.size() == 0 && !busy) break;
      @(negedge hclk);
    end
    n_tests++;
    if (sb.size() != 0 || busy !== 1'b0) begin
      n_fail++;
      $display("FAIL drain: got %0d outstanding busy=%b expected 0 outstanding busy=0", sb.size(), busy);
    end
  endtask

  task automatic check_err_count(input string name);
    n_tests++;
    if (err_count !== 8'(exp_err)) begin
      n_fail++;
      $display("FAIL %s: got err_count %0d expected %0d", name, err_count, exp_err);
    end
  endtask

  task automatic test_reset();
    hreset = 1'b1;
    #3;
    n_tests++;
    if ({hsel_x, htrans, hwrite, haddr, hwdata, done, err, timeout, busy, err_count} !== '0) begin
      n_fail++;
      $display("FAIL reset_outputs: got sel %b trans %b wr %b addr %h data %h d/e/t %b%b%b busy %b cnt %h expected all 0",
               hsel_x, htrans, hwrite, haddr, hwdata, done, err, timeout, busy, err_count);
    end
    n_tests++;
    if (req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_ready: got %b expected 1", req_ready);
    end
    @(negedge hclk);
    @(negedge hclk);
    hreset = 1'b0;
    @(negedge hclk);
  endtask

  task automatic test_single();
    hready = 1'b1; hresp = 1'b0;
    push(8'h00, 8'hA5, 1'b1, K_DONE);
    n_tests++;
    if (htrans !== 2'b00) begin
      n_fail++; $display("FAIL single_idle: got htrans %b expected 00", htrans);
    end
    @(negedge hclk);
    n_tests++;
    if ({hsel_x, hwrite, htrans, haddr} !== {1'b1, 1'b1, 2'b10, 8'h00}) begin
      n_fail++;
      $display("FAIL single_addr: got sel %b wr %b trans %b addr %h expected 1 1 10 00", hsel_x, hwrite, htrans, haddr);
    end
    @(negedge hclk);
    n_tests++;
    if ({hsel_x, hwrite, htrans, hwdata} !== {1'b1, 1'b0, 2'b00, 8'hA5}) begin
      n_fail++;
      $display("FAIL single_data: got sel %b wr %b trans %b data %h expected 1 0 00 a5", hsel_x, hwrite, htrans, hwdata);
    end
    @(negedge hclk);
    n_tests++;
    if (done !== 1'b1) begin
      n_fail++; $display("FAIL single_done: got %b expected 1", done);
    end
    @(negedge hclk);
    n_tests++;
    if ({done, busy, hsel_x} !== 3'b000) begin
      n_fail++; $display("FAIL single_after: got done %b busy %b sel %b expected 0 0 0", done, busy, hsel_x);
    end
    check_err_count("single_err_count");
  endtask

  task automatic test_fill();
    hready = 1'b0; hresp = 1'b0;
    stamps.delete();
    for (int i = 0; i < 4; i++) push(8'(i), 8'h10 + 8'(i), 1'b1, K_DONE);
    n_tests++;
    if (req_ready !== 1'b1) begin
      n_fail++; $display("FAIL fill_ready_4: got %b expected 1 (one request in flight)", req_ready);
    end
    push(8'h04, 8'h14, 1'b1, K_DONE);
    n_tests++;
    if (req_ready !== 1'b0) begin
      n_fail++; $display("FAIL fill_full: got req_ready %b expected 0", req_ready);
    end
    push(8'h05, 8'h15, 1'b0, K_DONE);
    hready = 1'b1;
    wait_drain();
    n_tests++;
    if (stamps.size() != 5) begin
      n_fail++; $display("FAIL fill_count: got %0d pulses expected 5", stamps.size());
    end else begin
      for (int i = 1; i < 5; i++) begin
        n_tests++;
        if (stamps[i] - stamps[i-1] != 3) begin
          n_fail++; $display("FAIL fill_period: got %0d cycles expected 3", stamps[i] - stamps[i-1]);
        end
      end
    end
  endtask

  task automatic test_wait_states();
    hready = 1'b1; hresp = 1'b0;
    stamps.delete();
    push(8'h01, 8'h3C, 1'b1, K_DONE);
    wait_addr();
    hready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      n_tests++;
      if (hwdata !== 8'h3C || done !== 1'b0) begin
        n_fail++; $display("FAIL wait_hold_%0d: got data %h done %b expected 3c 0", k, hwdata, done);
      end
      if (k == 3) hready = 1'b1;
      @(negedge hclk);
    end
    n_tests++;
    if (done !== 1'b1) begin
      n_fail++; $display("FAIL wait_done: got %b expected 1", done);
    end
    wait_drain();
    n_tests++;
    if (stamps.size() != 1) begin
      n_fail++; $display("FAIL wait_pulses: got %0d expected 1", stamps.size());
    end
  endtask

  task automatic test_error();
    hready = 1'b1; hresp = 1'b0;
    push(8'h02, 8'hE1, 1'b1, K_ERR);
    push(8'h00, 8'h5A, 1'b1, K_DONE);
    wait_addr();
    hready = 1'b0; hresp = 1'b1;
    @(negedge hclk);
    n_tests++;
    if ({err, done, hsel_x} !== 3'b001) begin
      n_fail++; $display("FAIL error_first: got err %b done %b sel %b expected 0 0 1", err, done, hsel_x);
    end
    hready = 1'b1;
    @(negedge hclk);
    n_tests++;
    if ({err, done} !== 2'b10) begin
      n_fail++; $display("FAIL error_pulse: got err %b done %b expected 1 0", err, done);
    end
    hresp = 1'b0;
    exp_err++;
    wait_drain();
    check_err_count("error_err_count");
  endtask

  task automatic test_timeout();
    hready = 1'b1; hresp = 1'b0;
    push(8'h03, 8'hC3, 1'b1, K_TMO);
    wait_addr();
    hready = 1'b0;
    for (int k = 1; k <= 16; k++) begin
      @(negedge hclk);
      n_tests++;
      if (timeout !== (k == 16)) begin
        n_fail++; $display("FAIL timeout_cycle_%0d: got %b expected %b", k, timeout, (k == 16));
      end
    end
    n_tests++;
    if ({hsel_x, htrans} !== 3'b000) begin
      n_fail++; $display("FAIL timeout_idle: got sel %b trans %b expected 0 00", hsel_x, htrans);
    end
    hready = 1'b1;
    exp_err++;
    wait_drain();
    check_err_count("timeout_err_count");
  endtask

  task automatic test_reset_mid();
    hready = 1'b1; hresp = 1'b0;
    push(8'h01, 8'h77, 1'b0, K_DONE);
    push(8'h02, 8'h88, 1'b0, K_DONE);
    wait_addr();
    hready = 1'b0;
    #2 hreset = 1'b1;
    #1;
    exp_err = 0;
    n_tests++;
    if ({hsel_x, htrans, hwrite, haddr, hwdata, done, err, timeout, busy, err_count} !== '0 || req_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL midreset_outputs: got sel %b trans %b addr %h data %h busy %b cnt %h ready %b expected zeros and ready 1",
               hsel_x, htrans, haddr, hwdata, busy, err_count, req_ready);
    end
    @(negedge hclk);
    hreset = 1'b0;
    hready = 1'b1;
    repeat (4) @(negedge hclk);
    n_tests++;
    if (busy !== 1'b0) begin
      n_fail++; $display("FAIL midreset_flushed: got busy %b expected 0", busy);
    end
    push(8'h00, 8'h5A, 1'b1, K_DONE);
    wait_drain();
    check_err_count("midreset_err_count");
  endtask

  initial begin
    req_valid = 1'b0; req_addr = '0; req_data = '0;
    hready = 1'b1; hresp = 1'b0;
    test_reset();
    test_single();
    test_fill();
    test_wait_states();
    test_error();
    test_timeout();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
